// File: rtl/fir_mac_ctrl.sv
// Stereo FIR multiply-accumulate controller: steps the coefficient ROM over one
// readout burst and emits a Q1.15 result per channel. Define FIR_SAT_EN for saturating output.
module fir_mac_ctrl #(
    parameter int TAPS = 1021,
    parameter int AW   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sequencing,
    input  logic signed [15:0]   lft_in,
    input  logic signed [15:0]   rght_in,
    input  logic signed [15:0]   coeff,
    output logic        [AW-1:0] coeff_addr,
    output logic signed [15:0]   lft_out,
    output logic signed [15:0]   rght_out,
    output logic                 valid,
    output logic                 err
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = DATA_W + COEF_W;
    // One spare count bit so an over-long burst can never alias back onto TAPS
    localparam int CW     = AW + 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(TAPS - 1);
    localparam logic [CW-1:0] TAPS_CNT  = CW'(TAPS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TAPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                    armed;
    logic                    acc_en;
    logic                    start;
    logic                    cnt_ok;
    logic        [CW-1:0]    tap_cnt;
    logic signed [ACC_W-1:0] acc_l, acc_r;
    logic signed [ACC_W-1:0] prod_l, prod_r;

    function automatic logic signed [DATA_W-1:0] to_out(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SAT_EN
        if (a[ACC_W-1 -: 2] == 2'b01)
            return 16'sh7FFF;
        else if (a[ACC_W-1 -: 2] == 2'b10)
            return 16'sh8000;
        else
            return a[30:15];
`else
        return a[30:15];
`endif
    endfunction

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a >= LAST_ADDR) ? LAST_ADDR : a + AW'(1);
    endfunction

    // A burst that was already running when reset lifted is skipped until sequencing drops
    assign start  = sequencing && armed && (state == IDLE || state == DONE);
    assign cnt_ok = (tap_cnt == TAPS_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (!sequencing) state_nxt = DRAIN;
            DRAIN:   state_nxt = cnt_ok ? DONE : IDLE;
            DONE:    state_nxt = start ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == DONE);
        err   = (state == DRAIN) && !cnt_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            acc_en     <= 1'b0;
            coeff_addr <= '0;
        end else begin
            if (!sequencing)
                armed <= 1'b1;
            acc_en <= sequencing;
            if (state == ACC && sequencing)
                coeff_addr <= addr_inc(coeff_addr);
            else if (start)
                coeff_addr <= addr_inc('0);
            else
                coeff_addr <= '0;
        end
    end

    // Stage: samples and ROM data arrive one cycle behind sequencing
    assign prod_l = ACC_W'(lft_in)  * ACC_W'(coeff);
    assign prod_r = ACC_W'(rght_in) * ACC_W'(coeff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_l   <= '0;
            acc_r   <= '0;
            tap_cnt <= '0;
        end else if (start) begin
            acc_l   <= '0;
            acc_r   <= '0;
            tap_cnt <= '0;
        end else if (acc_en) begin
            acc_l   <= acc_l + prod_l;
            acc_r   <= acc_r + prod_r;
            if (tap_cnt < CNT_MAX)
                tap_cnt <= tap_cnt + CW'(1);
        end
    end

    // Stage: results latch only on a complete burst, so an errored burst leaves them intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_out  <= '0;
            rght_out <= '0;
        end else if (state == DRAIN && cnt_ok) begin
            lft_out  <= to_out(acc_l);
            rght_out <= to_out(acc_r);
        end
    end

endmodule
